// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Holds the controller state encoding and the accumulator-to-element
// saturation helper used when a finished dot product is written back.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  // Widest accumulator and element the saturation helper handles.
  localparam int SAT_ACC_W  = 128;
  localparam int SAT_DATA_W = 64;

  // The value occupies the upper bits and the overflow flag the LSB, so a
  // caller may truncate the whole struct to DATA_W+1 bits and keep both.
  typedef struct packed {
    logic [SAT_DATA_W-1:0] value;
    logic                  ovf;
  } sat_t;

  // Clamp a sign-extended accumulator to a signed data_w-bit element and
  // report whether clamping happened.
  function automatic sat_t saturate(input logic signed [SAT_ACC_W-1:0] acc,
                                    input int unsigned               data_w);
    logic signed [SAT_ACC_W-1:0] max_v;
    logic signed [SAT_ACC_W-1:0] min_v;
    sat_t                        r;
    max_v   = $signed((SAT_ACC_W'(1) << (data_w - 1)) - SAT_ACC_W'(1));
    min_v   = -max_v - $signed(SAT_ACC_W'(1));
    r.value = acc[SAT_DATA_W-1:0];
    r.ovf   = 1'b0;
    if (acc > max_v) begin
      r.value = max_v[SAT_DATA_W-1:0];
      r.ovf   = 1'b1;
    end else if (acc < min_v) begin
      r.value = min_v[SAT_DATA_W-1:0];
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: acc += a*b when enabled, synchronous clear.
// The accumulator is wide enough that a full dot product never wraps.
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] product;

  // Operands are sign-extended to the full product width before multiplying.
  assign product = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  // Accumulator register: clear wins over enable so a new dot product starts at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(product);
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential matrix multiplier C = A x B, one MAC per clock.
// Operands are captured on start; each result element takes K MAC cycles
// plus one STORE cycle, then a single-cycle done pulse is produced.
// Optional feature: define MATMUL_RELU_EN to clamp negative results to zero
// at write-back (overflow still reports saturation before the clamp).
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [M*K*DATA_W-1:0]    a_flat,
  input  logic [K*N*DATA_W-1:0]    b_flat,
  output logic                     ready,
  output logic                     done,
  output logic [M*N*DATA_W-1:0]    result_flat,
  output logic                     overflow
);

  localparam int I_W = (M > 1) ? $clog2(M) : 1;
  localparam int J_W = (N > 1) ? $clog2(N) : 1;
  localparam int K_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [I_W-1:0] I_LAST = I_W'(M - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

  state_t state;
  state_t next_state;

  logic capture;
  logic mac_en;
  logic store;

  logic [I_W-1:0] i;
  logic [J_W-1:0] j;
  logic [K_W-1:0] k;

  logic signed [DATA_W-1:0] a_in    [M][K];
  logic signed [DATA_W-1:0] b_in    [K][N];
  logic signed [DATA_W-1:0] a_mat   [M][K];
  logic signed [DATA_W-1:0] b_mat   [K][N];
  logic signed [DATA_W-1:0] res_mat [M][N];

  logic signed [DATA_W-1:0] a_elem;
  logic signed [DATA_W-1:0] b_elem;
  logic signed [ACC_W-1:0]  acc;
  logic        [DATA_W:0]   sat_bits;
  logic                     sat_ovf;
  logic signed [DATA_W-1:0] store_val;

  // Unpack the flat row-major buses into element arrays.
  for (genvar gr = 0; gr < M; gr++) begin : g_a_row
    for (genvar gc = 0; gc < K; gc++) begin : g_a_col
      assign a_in[gr][gc] = a_flat[(gr*K + gc)*DATA_W +: DATA_W];
    end
  end

  for (genvar gr = 0; gr < K; gr++) begin : g_b_row
    for (genvar gc = 0; gc < N; gc++) begin : g_b_col
      assign b_in[gr][gc] = b_flat[(gr*N + gc)*DATA_W +: DATA_W];
    end
  end

  for (genvar gr = 0; gr < M; gr++) begin : g_r_row
    for (genvar gc = 0; gc < N; gc++) begin : g_r_col
      assign result_flat[(gr*N + gc)*DATA_W +: DATA_W] = res_mat[gr][gc];
    end
  end

  // Operand pair for the current MAC step: A(i,k) and B(k,j).
  assign a_elem = a_mat[i][k];
  assign b_elem = b_mat[k][j];

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (capture | store),
    .en    (mac_en),
    .a     (a_elem),
    .b     (b_elem),
    .acc   (acc)
  );

  // Saturate the finished dot product to an element, optionally applying ReLU.
  always_comb begin
    sat_bits = (DATA_W + 1)'(saturate(SAT_ACC_W'(acc), DATA_W));
    sat_ovf  = sat_bits[0];
`ifdef MATMUL_RELU_EN
    store_val = sat_bits[DATA_W] ? '0 : sat_bits[DATA_W:1];
`else
    store_val = sat_bits[DATA_W:1];
`endif
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    mac_en     = 1'b0;
    store      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          capture    = 1'b1;
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (k == K_LAST) next_state = S_STORE;
      end
      S_STORE: begin
        store = 1'b1;
        if (i == I_LAST && j == J_LAST) next_state = S_DONE;
        else                            next_state = S_MAC;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand copies taken at job start so later input changes cannot disturb the job.
  always_ff @(posedge clk) begin
    // NOTE: operand arrays are left out of reset; each job overwrites them before any use.
    if (capture) begin
      a_mat <= a_in;
      b_mat <= b_in;
    end
  end

  // Index walk, result write-back and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      overflow <= 1'b0;
      res_mat  <= '{default: '0};
    end else begin
      if (capture) begin
        i        <= '0;
        j        <= '0;
        k        <= '0;
        overflow <= 1'b0;
      end
      if (mac_en) begin
        k <= (k == K_LAST) ? '0 : k + K_W'(1);
      end
      if (store) begin
        res_mat[i][j] <= store_val;
        if (sat_ovf) overflow <= 1'b1;
        k <= '0;
        if (j == J_LAST) begin
          j <= '0;
          i <= (i == I_LAST) ? '0 : i + I_W'(1);
        end else begin
          j <= j + J_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: a 2x2x2 8-bit instance for directed and random jobs,
// and a 3x4x2 16-bit instance for back-to-back random jobs with start held.
// Expected results come from a plain-arithmetic matrix product reference.
module tb_matmul_seq;

  typedef struct {
    logic [95:0] res;
    bit          ovf;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  exp_t sq[$];
  exp_t bq[$];
  exp_t se;
  exp_t be;

  // Small instance: M=K=N=2, DATA_W=8
  logic        s_reset, s_start, s_ready, s_done, s_ovf;
  logic [31:0] s_a, s_b, s_res;

  // Large instance: M=3, K=4, N=2, DATA_W=16
  logic         b_reset, b_start, b_ready, b_done, b_ovf;
  logic [191:0] b_a;
  logic [127:0] b_b;
  logic [95:0]  b_res;

  matmul_seq #(.M(2), .K(2), .N(2), .DATA_W(8), .ACC_W(20)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .a_flat(s_a), .b_flat(s_b),
    .ready(s_ready), .done(s_done), .result_flat(s_res), .overflow(s_ovf)
  );

  matmul_seq #(.M(3), .K(4), .N(2), .DATA_W(16), .ACC_W(40)) u_big (
    .clk(clk), .reset(b_reset), .start(b_start), .a_flat(b_a), .b_flat(b_b),
    .ready(b_ready), .done(b_done), .result_flat(b_res), .overflow(b_ovf)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: C = A x B in exact integer arithmetic, clamp each element to
  // signed w bits, then pack row-major.
  function automatic exp_t model(input int m, input int kk, input int n, input int w,
                                 input longint a[$], input longint b[$]);
    exp_t   e;
    longint lim_hi, lim_lo, s;
    e.res      = '0;
    e.ovf      = 1'b0;
    e.done_cyc = 0;
    lim_hi = (longint'(1) <<< (w - 1)) - 1;
    lim_lo = -lim_hi - 1;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int t = 0; t < kk; t++) s += a[r*kk + t] * b[t*n + c];
        if (s > lim_hi) begin s = lim_hi; e.ovf = 1'b1; end
        else if (s < lim_lo) begin s = lim_lo; e.ovf = 1'b1; end
`ifdef MATMUL_RELU_EN
        if (s < 0) s = 0;
`endif
        e.res |= (96'(s) & ((96'(1) << w) - 96'(1))) << ((r*n + c)*w);
      end
    end
    return e;
  endfunction

  // Monitor: small instance
  always @(negedge clk) begin
    if (s_done) begin
      if (sq.size() == 0) begin
        check("small_unexpected_done", s_done, 0);
      end else begin
        se = sq.pop_front();
        check("small_result", s_res, se.res[31:0]);
        check("small_overflow", s_ovf, se.ovf);
        check("small_done_cycle", cyc, se.done_cyc);
        check("small_ready_at_done", s_ready, 0);
      end
    end
  end

  // Monitor: large instance
  always @(negedge clk) begin
    if (b_done) begin
      if (bq.size() == 0) begin
        check("big_unexpected_done", b_done, 0);
      end else begin
        be = bq.pop_front();
        check("big_result", b_res, be.res);
        check("big_overflow", b_ovf, be.ovf);
        check("big_done_cycle", cyc, be.done_cyc);
      end
    end
  end

  // Issue one job on the small instance; returns the capture edge index.
  task automatic small_job(input longint av[$], input longint bv[$], input bit disturb,
                           output int e_cyc);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check("small_ready_timeout", s_ready, 1);
    for (int x = 0; x < 4; x++) begin
      s_a[x*8 +: 8] = 8'(av[x]);
      s_b[x*8 +: 8] = 8'(bv[x]);
    end
    s_start = 1'b1;
    @(posedge clk);
    #1;
    e          = model(2, 2, 2, 8, av, bv);
    e.done_cyc = cyc + 2*2*(2+1);
    e_cyc      = cyc;
    sq.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
    if (disturb) begin
      s_a = $urandom;
      repeat (2) @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      s_b = $urandom;
      repeat (3) @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
    end
  endtask

  task automatic wait_small_drain();
    int waited;
    waited = 0;
    while (sq.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sq.size() != 0) check("small_done_timeout", sq.size(), 0);
    @(negedge clk);
  endtask

  task automatic small_seq();
    longint av[$];
    longint bv[$];
    int     e_cyc;
    logic [7:0] r8;

    av = '{1, 2, 3, 4};
    bv = '{5, 6, 7, 8};
    small_job(av, bv, 0, e_cyc);
    wait_small_drain();
`ifndef MATMUL_RELU_EN
    check("basic_values", s_res, 32'h322B1613);
`endif
    check("basic_overflow", s_ovf, 0);

    av = '{100, 100, -100, -100};
    bv = '{100, 100, 100, 100};
    small_job(av, bv, 0, e_cyc);
    wait_small_drain();
`ifndef MATMUL_RELU_EN
    check("saturate_values", s_res, 32'h80807F7F);
`endif
    check("saturate_overflow", s_ovf, 1);

    av = '{1, 2, 3, 4};
    bv = '{1, 1, 1, 1};
    small_job(av, bv, 0, e_cyc);
    wait_small_drain();
    check("overflow_cleared", s_ovf, 0);

    av = '{-1, 0, 0, -1};
    bv = '{1, 0, 0, 1};
    small_job(av, bv, 0, e_cyc);
    wait_small_drain();
`ifdef MATMUL_RELU_EN
    check("negative_identity", s_res, 32'h00000000);
`else
    check("negative_identity", s_res, 32'hFF0000FF);
`endif

    // Mid-job start pulses and operand changes must not affect the job.
    av = '{3, -2, 7, 1};
    bv = '{-4, 5, 2, 6};
    small_job(av, bv, 1, e_cyc);
    wait_small_drain();
    repeat (15) @(negedge clk);

    // Reset during MAC of element (1,0): edge E+6 begins that element.
    av = '{1, 2, 3, 4};
    bv = '{5, 6, 7, 8};
    small_job(av, bv, 0, e_cyc);
    while (cyc < e_cyc + 6) @(negedge clk);
    s_reset = 1'b1;
    sq.delete();
    @(negedge clk);
    s_reset = 1'b0;
    check("abort_ready", s_ready, 1);
    check("abort_result_cleared", s_res, 0);
    check("abort_overflow", s_ovf, 0);
    check("abort_no_done", s_done, 0);
    repeat (20) @(negedge clk);
    small_job(av, bv, 0, e_cyc);
    wait_small_drain();

    for (int n = 0; n < 12; n++) begin
      av.delete();
      bv.delete();
      for (int x = 0; x < 4; x++) begin
        r8 = 8'($urandom);
        av.push_back(longint'($signed(r8)));
        r8 = 8'($urandom);
        bv.push_back(longint'($signed(r8)));
      end
      small_job(av, bv, 0, e_cyc);
      wait_small_drain();
    end
  endtask

  // 100 jobs with start held high; consecutive captures are one job
  // (6 elements x 5 cycles) plus DONE plus IDLE = 32 edges apart.
  task automatic big_seq();
    longint     av[$];
    longint     bv[$];
    logic [15:0] r16;
    int         prev_e;
    int         waited;
    exp_t       e;
    prev_e = -1;
    for (int job = 0; job < 100; job++) begin
      waited = 0;
      @(negedge clk);
      while (!b_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!b_ready) begin
        check("big_ready_timeout", b_ready, 1);
        break;
      end
      av.delete();
      bv.delete();
      for (int x = 0; x < 12; x++) begin
        r16 = 16'($urandom);
        if (job % 2 == 0) av.push_back(longint'($urandom_range(400)) - 200);
        else              av.push_back(longint'($signed(r16)));
        b_a[x*16 +: 16] = 16'(av[x]);
      end
      for (int x = 0; x < 8; x++) begin
        r16 = 16'($urandom);
        if (job % 2 == 0) bv.push_back(longint'($urandom_range(400)) - 200);
        else              bv.push_back(longint'($signed(r16)));
        b_b[x*16 +: 16] = 16'(bv[x]);
      end
      b_start = 1'b1;
      @(posedge clk);
      #1;
      if (prev_e >= 0) check("big_back_to_back", cyc - prev_e, 32);
      prev_e     = cyc;
      e          = model(3, 4, 2, 16, av, bv);
      e.done_cyc = cyc + 3*2*(4+1);
      bq.push_back(e);
    end
    @(negedge clk);
    b_start = 1'b0;
  endtask

  initial begin
    int waited;
    s_reset = 1'b1;
    b_reset = 1'b1;
    s_start = 1'b0;
    b_start = 1'b0;
    s_a = '0;
    s_b = '0;
    b_a = '0;
    b_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_reset = 1'b0;
    b_reset = 1'b0;
    check("reset_small_ready", s_ready, 1);
    check("reset_small_done", s_done, 0);
    check("reset_small_result", s_res, 0);
    check("reset_small_overflow", s_ovf, 0);
    check("reset_big_ready", b_ready, 1);
    check("reset_big_result", b_res, 0);
    check("reset_big_overflow", b_ovf, 0);

    fork
      small_seq();
      big_seq();
    join

    waited = 0;
    while ((sq.size() != 0 || bq.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("small_pending", sq.size(), 0);
    check("big_pending", bq.size(), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
